inst_fetch_axi: RTL and testbench
=================================

// Module: inst_fetch_axi
// PURPOSE
//  Instruction-fetch stage between the PC register and the IF/ID pipeline register.
//  Turns each (pc, ce) pair into one AXI-Lite read on the instruction port.
//  Delivers the returned word with its PC through a one-entry valid/ready output buffer.
//  Raises a stall request so PC and ctrl hold while a fetch is outstanding.
// PARAMETERS
//  ADDR_W    32            address width (pc_i, m_araddr)
//  DATA_W    32            instruction / rdata width
//  NOP_INST  32'h00000000  word substituted when rresp != OKAY
//  ARPROT    3'b100        constant driven on m_arprot (instruction, secure, unprivileged)
// PORTS
//  clk           in   1       clock, all logic on rising edge
//  rst           in   1       synchronous reset, active-high
//  pc_i          in   ADDR_W  fetch address from PC register
//  ce_i          in   1       fetch enable from PC register (chip enable)
//  flush_i       in   1       discard in-flight fetch and buffered word (branch/exception)
//  inst_ready_i  in   1       IF/ID accepts inst_o this cycle
//  inst_o        out  DATA_W  fetched instruction (registered)
//  inst_pc_o     out  ADDR_W  address inst_o was fetched from (registered)
//  inst_valid_o  out  1       inst_o/inst_pc_o/inst_err_o valid
//  inst_err_o    out  1       fetch returned SLVERR/DECERR; inst_o = NOP_INST
//  stallreq_o    out  1       to ctrl: hold PC (combinational)
//  m_araddr      out  ADDR_W  AXI AR address
//  m_arprot      out  3       AXI AR prot = ARPROT
//  m_arvalid     out  1       AXI AR valid
//  m_arready     in   1       AXI AR ready
//  m_rdata       in   DATA_W  AXI R data
//  m_rresp       in   2       AXI R response
//  m_rvalid      in   1       AXI R valid
//  m_rready      out  1       AXI R ready
// BEHAVIOUR
//  Reset: state=IDLE, m_arvalid=0, m_rready=0, m_araddr=0, inst_valid_o=0, inst_o=0,
//   inst_pc_o=0, inst_err_o=0, discard=0. rst mid-transaction abandons it; no wait for R.
//  FSM IDLE -> ADDR -> DATA -> IDLE; one outstanding read max.
//   IDLE: launch when ce_i && !flush_i && !(inst_valid_o && !inst_ready_i):
//    latch m_araddr<=pc_i, m_arvalid<=1, -> ADDR. Issue latency 1 cycle after launch condition.
//   ADDR: m_arvalid and m_araddr held stable until m_arready; on handshake m_arvalid<=0,
//    m_rready<=1, -> DATA. Next cycle earliest R accept.
//   DATA: on m_rvalid&&m_rready: m_rready<=0, -> IDLE; if !discard: inst_o<=rdata (or NOP_INST
//    if rresp!=2'b00), inst_err_o<=(rresp!=0), inst_pc_o<=m_araddr, inst_valid_o<=1.
//  Output buffer: inst_valid_o clears when inst_ready_i && inst_valid_o, unless a beat is
//   written in same cycle (write wins, valid stays 1). A launch is blocked while buffer full
//   and not draining, so no beat can arrive into a full, stalled buffer.
//  stallreq_o = ce_i && !(state==DATA && m_rvalid && !discard && !flush_i); i.e. PC advances
//   exactly in the cycle a non-discarded beat is accepted. 0 whenever ce_i=0.
//  flush_i: clears inst_valid_o next edge; in ADDR/DATA sets discard=1 (AXI not aborted,
//   AR kept valid until accepted, R still consumed); discard clears on that R accept.
//   flush_i in IDLE blocks launch that cycle. flush_i with R accept same cycle: beat dropped.
//  Back-to-back: steady-state throughput one instruction per 3 cycles with zero-wait slave.
//  ce_i=0 in ADDR/DATA: transaction completes normally; no new launch.
// TESTING
//  Zero-wait slave, pc 0,4,8, ready=1 -> AR addrs 0x0,0x4,0x8; inst_o/inst_pc_o match, 1 per 3 clk.
//  arready delayed 5 clk -> m_arvalid/m_araddr stable 5 clk, stallreq_o=1 throughout.
//  rresp=2'b10 on pc=0x10 -> inst_o=NOP_INST, inst_err_o=1, inst_pc_o=0x10.
//  inst_ready_i=0 for 4 clk after beat -> inst_o held, no AR issued until ready.
//  flush_i in DATA at pc=0x20 -> beat consumed, inst_valid_o stays 0; next fetch uses new pc_i.
//  rst asserted in ADDR -> all outputs to reset values next edge; later fetch of 0x0 correct.

Source files
------------

// File: rtl/inst_fetch_axi.sv
// Instruction-fetch stage: turns each (pc, ce) request into one AXI-Lite read and
// presents the returned word with its PC through a one-entry valid/ready buffer.
module inst_fetch_axi #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [DATA_W-1:0] NOP_INST = 32'h00000000,
   parameter logic [2:0]        ARPROT   = 3'b100
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              ce_i,
   input  logic              flush_i,
   input  logic              inst_ready_i,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc_o,
   output logic              inst_valid_o,
   output logic              inst_err_o,
   output logic              stallreq_o,
   output logic [ADDR_W-1:0] m_araddr,
   output logic [2:0]        m_arprot,
   output logic              m_arvalid,
   input  logic              m_arready,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic [1:0]        m_rresp,
   input  logic              m_rvalid,
   output logic              m_rready
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t state;
   state_t next_state;
   logic   discard;
   logic   launch;
   logic   ar_hs;
   logic   r_hs;
   logic   beat_write;
   logic   resp_err;

   // A full buffer that is not draining blocks launch, so a beat never lands on a stalled entry.
   assign launch     = ce_i && !flush_i && !(inst_valid_o && !inst_ready_i);
   assign ar_hs      = (state == ADDR) && m_arvalid && m_arready;
   assign r_hs       = (state == DATA) && m_rvalid && m_rready;
   assign beat_write = r_hs && !discard && !flush_i;
   assign resp_err   = (m_rresp != 2'b00);
   assign m_arprot   = ARPROT;

   // PC may advance only in the cycle a beat that will be kept is accepted.
   assign stallreq_o = ce_i && !((state == DATA) && m_rvalid && !discard && !flush_i);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (launch) next_state = ADDR;
         ADDR:    if (ar_hs)  next_state = DATA;
         DATA:    if (r_hs)   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_araddr     <= '0;
         m_arvalid    <= 1'b0;
         m_rready     <= 1'b0;
         discard      <= 1'b0;
         inst_o       <= '0;
         inst_pc_o    <= '0;
         inst_err_o   <= 1'b0;
         inst_valid_o <= 1'b0;
      end else begin
         if ((state == IDLE) && launch) begin
            m_araddr  <= pc_i;
            m_arvalid <= 1'b1;
         end
         if (ar_hs) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
         end
         if (r_hs) begin
            m_rready <= 1'b0;
         end

         // A flushed transaction still runs to completion on AXI; its beat is dropped.
         if (r_hs) begin
            discard <= 1'b0;
         end else if (flush_i && (state != IDLE)) begin
            discard <= 1'b1;
         end

         if (beat_write) begin
            inst_o       <= resp_err ? NOP_INST : m_rdata;
            inst_err_o   <= resp_err;
            inst_pc_o    <= m_araddr;
            inst_valid_o <= 1'b1;
         end else if (flush_i || (inst_ready_i && inst_valid_o)) begin
            inst_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch_axi.sv
// Directed bench for inst_fetch_axi: a scripted AXI-Lite slave, a PC register model
// and hand-computed expectations checked with immediate assertions.
module tb_inst_fetch_axi;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic        ce_i;
   logic        flush_i;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_valid_o;
   logic        inst_err_o;
   logic        stallreq_o;
   logic [31:0] m_araddr;
   logic [2:0]  m_arprot;
   logic        m_arvalid;
   logic        m_arready;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rvalid;
   logic        m_rready;

   int          compared   = 0;
   int          mismatched = 0;
   int          arWait     = 0;
   logic [1:0]  respCode   = 2'b00;

   inst_fetch_axi dut (
      .clk          (clk),
      .rst          (rst),
      .pc_i         (pc_i),
      .ce_i         (ce_i),
      .flush_i      (flush_i),
      .inst_ready_i (inst_ready_i),
      .inst_o       (inst_o),
      .inst_pc_o    (inst_pc_o),
      .inst_valid_o (inst_valid_o),
      .inst_err_o   (inst_err_o),
      .stallreq_o   (stallreq_o),
      .m_araddr     (m_araddr),
      .m_arprot     (m_arprot),
      .m_arvalid    (m_arvalid),
      .m_arready    (m_arready),
      .m_rdata      (m_rdata),
      .m_rresp      (m_rresp),
      .m_rvalid     (m_rvalid),
      .m_rready     (m_rready)
   );

   always #5 clk = ~clk;

   // Memory image: each word encodes its own address so misrouted data shows up.
   function automatic logic [31:0] instFor(input logic [31:0] addr);
      return 32'hA500_0000 | addr;
   endfunction

   task automatic driveSlave();
      m_arready = 1'b0;
      if (m_arvalid) begin
         if (arWait > 0) arWait = arWait - 1;
         else m_arready = 1'b1;
      end
      m_rvalid = m_rready;
      m_rdata  = m_rready ? instFor(m_araddr) : 32'h0;
      m_rresp  = m_rready ? respCode : 2'b00;
   endtask

   // One clock: PC register advances when the stage did not request a stall.
   task automatic tick();
      logic adv;
      adv = ce_i && !stallreq_o;
      @(posedge clk);
      #1;
      if (adv) pc_i = pc_i + 32'd4;
      driveSlave();
      #1;
   endtask

   task automatic applyStimulus(input logic ce, input logic [31:0] pc, input logic ready,
                                input logic flush);
      ce_i         = ce;
      pc_i         = pc;
      inst_ready_i = ready;
      flush_i      = flush;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compared = compared + 1;
      assert (observed === expected)
      else begin
         mismatched = mismatched + 1;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      checkOutput("rst_arvalid", m_arvalid, 0);
      checkOutput("rst_rready", m_rready, 0);
      checkOutput("rst_araddr", m_araddr, 0);
      checkOutput("rst_valid", inst_valid_o, 0);
      checkOutput("rst_inst", inst_o, 0);
      checkOutput("rst_pc", inst_pc_o, 0);
      checkOutput("rst_err", inst_err_o, 0);
      checkOutput("rst_stall_ce0", stallreq_o, 0);
      checkOutput("arprot", m_arprot, 3'b100);

      // Zero-wait slave: three fetches, one per three cycles.
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("zw_arvalid", m_arvalid, 1);
         checkOutput("zw_araddr", m_araddr, 32'(4 * k));
         checkOutput("zw_stall_addr", stallreq_o, 1);
         tick();
         checkOutput("zw_rready", m_rready, 1);
         checkOutput("zw_stall_data", stallreq_o, 0);
         tick();
         checkOutput("zw_valid", inst_valid_o, 1);
         checkOutput("zw_inst", inst_o, 32'hA500_0000 + 32'(4 * k));
         checkOutput("zw_pc", inst_pc_o, 32'(4 * k));
      end
      ce_i = 1'b0;
      #1;
      checkOutput("ce0_stall", stallreq_o, 0);
      tick();
      checkOutput("ce0_no_launch", m_arvalid, 0);
      checkOutput("ce0_drained", inst_valid_o, 0);
      checkOutput("ce0_pc_hold", pc_i, 32'hC);

      // AR accepted only after five cycles of back-pressure.
      arWait = 5;
      applyStimulus(1'b1, 32'hC, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("arw_arvalid", m_arvalid, 1);
         checkOutput("arw_araddr", m_araddr, 32'hC);
         checkOutput("arw_stall", stallreq_o, 1);
         checkOutput("arw_rready", m_rready, 0);
      end
      tick();
      checkOutput("arw_held", m_arvalid, 1);
      tick();
      checkOutput("arw_data", m_rready, 1);
      tick();
      checkOutput("arw_inst", inst_o, 32'hA500_000C);
      checkOutput("arw_pc", inst_pc_o, 32'hC);

      // SLVERR response on 0x10 yields NOP with error flag.
      respCode = 2'b10;
      tick();
      checkOutput("err_araddr", m_araddr, 32'h10);
      tick();
      tick();
      checkOutput("err_inst", inst_o, 32'h0);
      checkOutput("err_flag", inst_err_o, 1);
      checkOutput("err_pc", inst_pc_o, 32'h10);
      checkOutput("err_valid", inst_valid_o, 1);
      respCode = 2'b00;
      tick();
      tick();
      tick();
      checkOutput("ok_inst", inst_o, 32'hA500_0014);
      checkOutput("ok_err", inst_err_o, 0);

      // Downstream not ready for four cycles: word held, no new AR.
      inst_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("bp_arvalid", m_arvalid, 0);
         checkOutput("bp_valid", inst_valid_o, 1);
         checkOutput("bp_inst", inst_o, 32'hA500_0014);
         checkOutput("bp_stall", stallreq_o, 1);
      end
      inst_ready_i = 1'b1;
      tick();
      checkOutput("bp_release_araddr", m_araddr, 32'h18);
      checkOutput("bp_release_valid", inst_valid_o, 0);
      tick();
      tick();
      checkOutput("bp_after_inst", inst_o, 32'hA500_0018);

      // Flush while in DATA: beat consumed and dropped, next fetch from new target.
      pc_i = 32'h20;
      tick();
      checkOutput("fd_araddr", m_araddr, 32'h20);
      tick();
      flush_i = 1'b1;
      pc_i    = 32'h40;
      #1;
      checkOutput("fd_stall", stallreq_o, 1);
      tick();
      flush_i = 1'b0;
      #1;
      checkOutput("fd_valid", inst_valid_o, 0);
      checkOutput("fd_inst_hold", inst_o, 32'hA500_0018);
      checkOutput("fd_rready", m_rready, 0);
      checkOutput("fd_pc_hold", pc_i, 32'h40);
      tick();
      checkOutput("fd_new_araddr", m_araddr, 32'h40);
      tick();
      tick();
      checkOutput("fd_new_inst", inst_o, 32'hA500_0040);
      checkOutput("fd_new_pc", inst_pc_o, 32'h40);

      // Flush while AR still waiting: AR kept valid, R consumed, beat dropped.
      arWait = 2;
      tick();
      checkOutput("fa_araddr", m_araddr, 32'h44);
      flush_i = 1'b1;
      pc_i    = 32'h80;
      tick();
      flush_i = 1'b0;
      #1;
      checkOutput("fa_arvalid", m_arvalid, 1);
      checkOutput("fa_araddr_hold", m_araddr, 32'h44);
      checkOutput("fa_valid", inst_valid_o, 0);
      tick();
      tick();
      checkOutput("fa_data_stall", stallreq_o, 1);
      tick();
      checkOutput("fa_dropped", inst_valid_o, 0);
      checkOutput("fa_idle", m_arvalid, 0);
      tick();
      checkOutput("fa_new_araddr", m_araddr, 32'h80);
      tick();
      tick();
      checkOutput("fa_new_inst", inst_o, 32'hA500_0080);

      // Reset while in ADDR abandons the read.
      arWait = 3;
      tick();
      checkOutput("ra_araddr", m_araddr, 32'h84);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      arWait = 0;
      pc_i = 32'h0;
      #1;
      checkOutput("ra_arvalid", m_arvalid, 0);
      checkOutput("ra_araddr0", m_araddr, 0);
      checkOutput("ra_inst0", inst_o, 0);
      checkOutput("ra_valid0", inst_valid_o, 0);
      tick();
      checkOutput("ra_refetch_addr", m_araddr, 32'h0);
      checkOutput("ra_refetch_arvalid", m_arvalid, 1);
      tick();
      tick();
      checkOutput("ra_refetch_inst", inst_o, 32'hA500_0000);
      checkOutput("ra_refetch_pc", inst_pc_o, 32'h0);
      checkOutput("ra_refetch_valid", inst_valid_o, 1);
      ce_i = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
